// File: rtl/wb_sram_arb_pkg.sv
// Shared types and the round-robin pick rule for the two-master SRAM arbiter.
package wb_sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // On a tie the master that was not served last wins.
  function automatic arb_state_t rr_pick(input logic req0, input logic req1, input logic last);
    arb_state_t pick;
    if (req0 && req1) begin
      pick = last ? GNT0 : GNT1;
    end else if (req0) begin
      pick = GNT0;
    end else if (req1) begin
      pick = GNT1;
    end else begin
      pick = IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_sram_arb_rr2.sv
// Next-grant logic: holds a grant while its cyc is high and re-arbitrates in
// the same cycle the owner releases, so no idle bubble is inserted.
module wb_sram_arb_rr2
  import wb_sram_arb_pkg::*;
(
  input  arb_state_t i_state,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last,
  input  logic       i_wdt_fire,
  output arb_state_t o_next_state,
  output logic       o_next_last
);

  // Grant transition and round-robin pointer update.
  always_comb begin
    o_next_state = i_state;
    o_next_last  = i_last;
    case (i_state)
      IDLE: begin
        o_next_state = rr_pick(i_req0, i_req1, i_last);
      end
      GNT0: begin
        if (i_wdt_fire) begin
          o_next_state = IDLE;
          o_next_last  = 1'b0;
        end else if (!i_req0) begin
          o_next_state = rr_pick(i_req0, i_req1, 1'b0);
          o_next_last  = 1'b0;
        end else begin
          o_next_state = GNT0;
        end
      end
      GNT1: begin
        if (i_wdt_fire) begin
          o_next_state = IDLE;
          o_next_last  = 1'b1;
        end else if (!i_req1) begin
          o_next_state = rr_pick(i_req0, i_req1, 1'b1);
          o_next_last  = 1'b1;
        end else begin
          o_next_state = GNT1;
        end
      end
      default: begin
        o_next_state = IDLE;
        o_next_last  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_sram_arb2.sv
// Two-master Wishbone arbiter in front of a single-port SRAM: registered
// round-robin grant, combinational data/termination paths, optional watchdog.
module wb_sram_arb2
  import wb_sram_arb_pkg::*;
#(
  parameter  int AW      = 32,
  parameter  int DW      = 32,
  parameter  int TIMEOUT = 0,
  localparam int SW      = DW / 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic [1:0]    m0_bte_i,
  input  logic [2:0]    m0_cti_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,
  output logic [DW-1:0] m0_dat_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic [1:0]    m1_bte_i,
  input  logic [2:0]    m1_cti_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,
  output logic [DW-1:0] m1_dat_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  output logic [SW-1:0] s_sel_o,
  output logic [1:0]    s_bte_o,
  output logic [2:0]    s_cti_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i,
  input  logic [DW-1:0] s_dat_i
);

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WDT_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  arb_state_t     r_state;
  arb_state_t     w_next_state;
  logic           r_last;
  logic           w_next_last;
  logic [WDW-1:0] r_wdt;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_stb_raw;
  logic           w_term;
  logic           w_fire;

  assign w_gnt0    = (r_state == GNT0);
  assign w_gnt1    = (r_state == GNT1);
  assign w_term    = s_ack_i | s_err_i | s_rty_i;
  assign w_stb_raw = (w_gnt0 & m0_stb_i) | (w_gnt1 & m1_stb_i);
  // Fires on the TIMEOUT-th consecutive unterminated strobe; a same-cycle ack wins.
  assign w_fire    = (TIMEOUT > 0) && w_stb_raw && !w_term && (r_wdt == WDT_LAST);

  wb_sram_arb_rr2 u_rr2 (
    .i_state      (r_state),
    .i_req0       (m0_cyc_i),
    .i_req1       (m1_cyc_i),
    .i_last       (r_last),
    .i_wdt_fire   (w_fire),
    .o_next_state (w_next_state),
    .o_next_last  (w_next_last)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_wdt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_last  <= w_next_last;
      if ((TIMEOUT == 0) || !w_stb_raw || w_term || w_fire) begin
        r_wdt <= '0;
      end else begin
        r_wdt <= r_wdt + WDW'(1);
      end
    end
  end

  always_comb begin
    s_adr_o = m0_adr_i;
    s_dat_o = m0_dat_i;
    s_sel_o = m0_sel_i;
    s_bte_o = m0_bte_i;
    s_cti_o = m0_cti_i;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    case (r_state)
      GNT0: begin
        s_cyc_o = m0_cyc_i & ~w_fire;
        s_stb_o = m0_stb_i & ~w_fire;
        s_we_o  = m0_we_i;
      end
      GNT1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_bte_o = m1_bte_i;
        s_cti_o = m1_cti_i;
        s_cyc_o = m1_cyc_i & ~w_fire;
        s_stb_o = m1_stb_i & ~w_fire;
        s_we_o  = m1_we_i;
      end
      default: begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
      end
    endcase
  end

  assign m0_ack_o = w_gnt0 & s_ack_i;
  assign m0_err_o = w_gnt0 & (s_err_i | w_fire);
  assign m0_rty_o = w_gnt0 & s_rty_i;
  assign m1_ack_o = w_gnt1 & s_ack_i;
  assign m1_err_o = w_gnt1 & (s_err_i | w_fire);
  assign m1_rty_o = w_gnt1 & s_rty_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule
